mul_share_sched: RTL and testbench

Scheduler that shares one pipelined 32-bit multiplier between several dataflow operators in a dynamically scheduled graph. Each requester hands over an operand pair with a valid/ready handshake, and a round-robin arbiter issues at most one product per cycle. Tagged results return on that requester's own valid/ready output port. The block sits between the graph's multiply nodes (for example the `k*a` / `k*b` branches of a conditional graph) and a single multiplier instance, so area is shared without breaking elastic semantics.

---
 rtl/mul_share_sched_if.sv | 34 +++
 rtl/mul_share_sched.sv | 167 ++++++++++++++++
 tb/tb_mul_share_sched.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_share_sched_if.sv
// Operand/result bundle between the multiply requesters and the shared multiplier scheduler.
// The requester side drives operands and result-ready. The scheduler side drives grants and results.
interface mul_share_sched_if #(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned WIDTH = 32
);
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] res_out;
    logic [N_REQ-1:0]       res_valid;
    logic [N_REQ-1:0]       res_ready;

    modport master (
        output req_a,
        output req_b,
        output req_valid,
        input  req_ready,
        input  res_out,
        input  res_valid,
        output res_ready
    );

    modport slave (
        input  req_a,
        input  req_b,
        input  req_valid,
        output req_ready,
        output res_out,
        output res_valid,
        input  res_ready
    );
endinterface

// File: rtl/mul_share_sched.sv
// Round-robin scheduler sharing one pipelined multiplier among N_REQ elastic requesters.
// Each port has at most one op outstanding, so the pipe never stalls and results never collide.
module mul_share_sched #(
    parameter int unsigned N_REQ   = 2,
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned MUL_LAT = 3
) (
    input logic             clk,
    input logic             rst,
    mul_share_sched_if.slave bus
);
    localparam int unsigned TagW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned HalfW = WIDTH / 2;
    localparam int unsigned HighW = WIDTH - HalfW;

    typedef logic [TagW-1:0] tag_t;
    typedef enum logic [1:0] {StIdle, StInflight, StDone} port_state_e;

    port_state_e            state_q [N_REQ];
    port_state_e            state_d [N_REQ];
    logic [N_REQ-1:0]       eligible;
    logic [N_REQ-1:0]       grant;
    logic                   found;
    int unsigned            idx;
    tag_t                   grant_idx;
    tag_t                   last_grant_q;
    logic                   issue;
    logic [WIDTH-1:0]       issue_a;
    logic [WIDTH-1:0]       issue_b;
    logic [WIDTH-1:0]       issue_lo;
    logic [HighW-1:0]       issue_hi;
    logic [MUL_LAT-1:0]     pipe_valid_q;
    tag_t                   pipe_tag_q [MUL_LAT];
    logic [WIDTH-1:0]       pipe_lo_q  [MUL_LAT];
    logic [HighW-1:0]       pipe_hi_q  [MUL_LAT];
    logic                   exit_valid;
    tag_t                   exit_tag;
    logic [WIDTH-1:0]       exit_prod;
    logic [WIDTH-1:0]       res_q [N_REQ];

    // Low WIDTH bits of a*b as lo + (hi << HalfW). Modular arithmetic makes this equal to the
    // low bits of the signed product, so no sign handling is needed.
    function automatic logic [WIDTH-1:0] combine(input logic [WIDTH-1:0] lo,
                                                 input logic [HighW-1:0] hi);
        return lo + {hi, {HalfW{1'b0}}};
    endfunction

    always_comb begin
        eligible = '0;
        for (int i = 0; i < N_REQ; i++) begin
            eligible[i] = rst && (state_q[i] == StIdle) && bus.req_valid[i];
        end
    end

    // Search starts one past the last winner; first eligible port takes the slot.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(last_grant_q) + 1 + k) % N_REQ;
            if (!found && eligible[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = tag_t'(idx);
            end
        end
    end

    assign issue         = found;
    assign bus.req_ready = grant;

    always_comb begin
        issue_a  = bus.req_a[int'(grant_idx)*WIDTH +: WIDTH];
        issue_b  = bus.req_b[int'(grant_idx)*WIDTH +: WIDTH];
        issue_lo = issue_a * {{HighW{1'b0}}, issue_b[HalfW-1:0]};
        issue_hi = issue_a[HighW-1:0] * issue_b[WIDTH-1:HalfW];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_q <= tag_t'(N_REQ - 1);
        end else if (issue) begin
            last_grant_q <= grant_idx;
        end
    end

    // Stage 0 holds the two partial products; later stages hold the folded product.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_valid_q <= '0;
            for (int s = 0; s < MUL_LAT; s++) begin
                pipe_tag_q[s] <= '0;
                pipe_lo_q[s]  <= '0;
                pipe_hi_q[s]  <= '0;
            end
        end else begin
            pipe_valid_q[0] <= issue;
            pipe_tag_q[0]   <= grant_idx;
            pipe_lo_q[0]    <= issue_lo;
            pipe_hi_q[0]    <= issue_hi;
            for (int s = 1; s < MUL_LAT; s++) begin
                pipe_valid_q[s] <= pipe_valid_q[s-1];
                pipe_tag_q[s]   <= pipe_tag_q[s-1];
                pipe_lo_q[s]    <= combine(pipe_lo_q[s-1], pipe_hi_q[s-1]);
                pipe_hi_q[s]    <= '0;
            end
        end
    end

    always_comb begin
        exit_valid = pipe_valid_q[MUL_LAT-1];
        exit_tag   = pipe_tag_q[MUL_LAT-1];
        exit_prod  = combine(pipe_lo_q[MUL_LAT-1], pipe_hi_q[MUL_LAT-1]);
    end

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            state_d[i] = state_q[i];
            unique case (state_q[i])
                StIdle:     if (grant[i]) state_d[i] = StInflight;
                StInflight: if (exit_valid && (exit_tag == tag_t'(i))) state_d[i] = StDone;
                StDone:     if (bus.res_ready[i]) state_d[i] = StIdle;
                default:    state_d[i] = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_REQ; i++) begin
                state_q[i] <= StIdle;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                state_q[i] <= state_d[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_REQ; i++) begin
                res_q[i] <= '0;
            end
        end else if (exit_valid) begin
            res_q[exit_tag] <= exit_prod;
        end
    end

    always_comb begin
        bus.res_out   = '0;
        bus.res_valid = '0;
        for (int i = 0; i < N_REQ; i++) begin
            bus.res_out[i*WIDTH +: WIDTH] = res_q[i];
            bus.res_valid[i]              = (state_q[i] == StDone);
        end
    end

`ifndef SYNTHESIS
    a_grant_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(grant));
    a_grant_eligible: assert property (@(posedge clk) disable iff (!rst)
                                       ((grant & ~eligible) == '0));
`endif

endmodule

// File: tb/tb_mul_share_sched.sv
// Directed and randomised bench for mul_share_sched with N_REQ=2, WIDTH=32, MUL_LAT=3.
module tb_mul_share_sched;
    logic        clk;
    logic        rst;
    logic [31:0] a_drv [2];
    logic [31:0] b_drv [2];
    logic [1:0]  v_drv;
    logic [1:0]  rr_drv;
    int          n_checks;
    int          n_errors;
    logic [31:0] exp_q0 [$];
    logic [31:0] exp_q1 [$];

    mul_share_sched_if #(.N_REQ(2), .WIDTH(32)) bus ();

    assign bus.req_a     = {a_drv[1], a_drv[0]};
    assign bus.req_b     = {b_drv[1], b_drv[0]};
    assign bus.req_valid = v_drv;
    assign bus.res_ready = rr_drv;

    mul_share_sched #(.N_REQ(2), .WIDTH(32), .MUL_LAT(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] golden(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] full;
        full = $signed(a) * $signed(b);
        return full[31:0];
    endfunction

    // Called at a negedge with port p idle and res_ready[p]=1.
    task automatic do_op(input int p, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string tag);
        int n;
        a_drv[p] = a;
        b_drv[p] = b;
        v_drv[p] = 1'b1;
        #1;
        n = 0;
        while (!bus.req_ready[p] && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        check_eq({tag, "_grant"}, 64'(bus.req_ready[p]), 64'd1);
        @(posedge clk); #1;
        v_drv[p] = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.res_valid[p] && n < 20);
        check_eq({tag, "_lat"}, 64'(n - 1), 64'd3);
        check_eq({tag, "_val"}, 64'(bus.res_out[p*32 +: 32]), 64'(exp));
        @(negedge clk);
    endtask

    task automatic drive_port(input int p);
        int gap;
        int n;
        for (int k = 0; k < 100; k++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
            a_drv[p] = $urandom;
            b_drv[p] = $urandom;
            v_drv[p] = 1'b1;
            #1;
            n = 0;
            while (!bus.req_ready[p] && n < 200) begin
                @(negedge clk); #1;
                n++;
            end
            if (n >= 200) begin
                check_eq("rand_grant_timeout", 64'(p), 64'hFF);
                v_drv[p] = 1'b0;
                return;
            end
            @(posedge clk);
            if (p == 0) exp_q0.push_back(golden(a_drv[0], b_drv[0]));
            else        exp_q1.push_back(golden(a_drv[1], b_drv[1]));
            #1;
            v_drv[p] = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic monitor_rand();
        int          got [2];
        logic [31:0] e;
        got[0] = 0;
        got[1] = 0;
        for (int cyc = 0; cyc < 8000 && !(got[0] == 100 && got[1] == 100); cyc++) begin
            @(negedge clk);
            rr_drv[0] = ($urandom_range(0, 3) != 0);
            rr_drv[1] = ($urandom_range(0, 3) != 0);
            #1;
            for (int p = 0; p < 2; p++) begin
                if (bus.res_valid[p] && rr_drv[p]) begin
                    got[p]++;
                    if ((p == 0 && exp_q0.size() == 0) || (p == 1 && exp_q1.size() == 0)) begin
                        check_eq("rand_dup", 64'(p), 64'hFF);
                    end else begin
                        e = (p == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        check_eq(p == 0 ? "rand_p0" : "rand_p1",
                                 64'(bus.res_out[p*32 +: 32]), 64'(e));
                    end
                end
            end
        end
        check_eq("rand_cnt0", 64'(got[0]), 64'd100);
        check_eq("rand_cnt1", 64'(got[1]), 64'd100);
    endtask

    initial begin
        int n;
        int bad;
        int bad0;
        int p0cnt;
        int r0cnt;
        int r1cnt;
        int multi;
        int gq [$];

        n_checks = 0;
        n_errors = 0;
        rst      = 1'b0;
        a_drv[0] = '0; a_drv[1] = '0;
        b_drv[0] = '0; b_drv[1] = '0;
        v_drv    = 2'b11;
        rr_drv   = 2'b11;

        #3;
        check_eq("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check_eq("rst_res_valid", 64'(bus.res_valid), 64'd0);
        check_eq("rst_res_out", 64'(bus.res_out), 64'd0);
        repeat (2) @(negedge clk);
        v_drv = 2'b00;
        rst   = 1'b1;

        // Single request and port isolation.
        do_op(0, 32'd7, 32'd6, 32'd42, "single");
        check_eq("single_p1_out", 64'(bus.res_out[63:32]), 64'd0);
        check_eq("single_p1_valid", 64'(bus.res_valid[1]), 64'd0);

        // Signed wrap-around.
        do_op(0, 32'hFFFFFFFB, 32'd3, 32'hFFFFFFF1, "neg5x3");
        do_op(1, 32'h7FFFFFFF, 32'd2, 32'hFFFFFFFE, "maxx2");
        do_op(0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "minxm1");

        // Reset with two ops in flight; last grant was port 0 so port 1 wins first.
        rr_drv   = 2'b00;
        a_drv[0] = 32'd1; b_drv[0] = 32'd2;
        a_drv[1] = 32'd3; b_drv[1] = 32'd4;
        v_drv    = 2'b11;
        #1;
        check_eq("mid_rr_first", 64'(bus.req_ready), 64'b10);
        @(posedge clk); #1;
        v_drv[1] = 1'b0;
        @(negedge clk); #1;
        check_eq("mid_rr_second", 64'(bus.req_ready), 64'b01);
        @(posedge clk); #1;
        v_drv[0] = 1'b0;
        n = 0;
        while (!bus.res_valid[1] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("mid_pre_valid", 64'(bus.res_valid), 64'b10);
        #2;
        rst = 1'b0;
        #1;
        check_eq("mid_async_valid", 64'(bus.res_valid), 64'd0);
        check_eq("mid_async_out", 64'(bus.res_out), 64'd0);
        repeat (2) @(negedge clk);
        rst    = 1'b1;
        rr_drv = 2'b11;
        bad    = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.res_valid != 2'b00) bad++;
        end
        check_eq("mid_no_stale", 64'(bad), 64'd0);

        // Contention: both ports request continuously, results consumed on arrival.
        a_drv[0] = 32'd2; b_drv[0] = 32'd3;
        a_drv[1] = 32'd4; b_drv[1] = 32'd5;
        v_drv    = 2'b11;
        #1;
        check_eq("cont_first_grant", 64'(bus.req_ready), 64'b01);
        bad   = 0;
        r0cnt = 0;
        r1cnt = 0;
        multi = 0;
        repeat (30) begin
            if (bus.req_ready == 2'b01) gq.push_back(0);
            else if (bus.req_ready == 2'b10) gq.push_back(1);
            else if (bus.req_ready != 2'b00) multi++;
            if (bus.res_valid[0]) begin
                r0cnt++;
                if (bus.res_out[31:0] != 32'd6) bad++;
            end
            if (bus.res_valid[1]) begin
                r1cnt++;
                if (bus.res_out[63:32] != 32'd20) bad++;
            end
            @(negedge clk); #1;
        end
        for (int i = 0; i < 4; i++) begin
            check_eq("cont_grant_seq", 64'((i < gq.size()) ? gq[i] : 99), 64'(i % 2));
        end
        check_eq("cont_onehot", 64'(multi), 64'd0);
        check_eq("cont_results", 64'(bad), 64'd0);
        check_eq("cont_r0_seen", 64'(r0cnt >= 2), 64'd1);
        check_eq("cont_r1_seen", 64'(r1cnt >= 2), 64'd1);
        v_drv = 2'b00;
        repeat (8) @(negedge clk);

        // Backpressure on port 1 while port 0 keeps running.
        rr_drv   = 2'b01;
        a_drv[1] = 32'd9; b_drv[1] = 32'd9;
        v_drv[1] = 1'b1;
        #1;
        n = 0;
        while (!bus.req_ready[1] && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        a_drv[1] = 32'd10; b_drv[1] = 32'd10;
        n = 0;
        while (!bus.res_valid[1] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("bp_held_value", 64'(bus.res_out[63:32]), 64'd81);
        a_drv[0] = 32'd3; b_drv[0] = 32'd7;
        v_drv[0] = 1'b1;
        #1;
        bad   = 0;
        bad0  = 0;
        p0cnt = 0;
        repeat (20) begin
            if (bus.res_valid[1] !== 1'b1 || bus.res_out[63:32] !== 32'd81 ||
                bus.req_ready[1] !== 1'b0) bad++;
            if (bus.res_valid[0]) begin
                p0cnt++;
                if (bus.res_out[31:0] != 32'd21) bad0++;
            end
            @(negedge clk); #1;
        end
        check_eq("bp_stable", 64'(bad), 64'd0);
        check_eq("bp_p0_values", 64'(bad0), 64'd0);
        check_eq("bp_p0_progress", 64'(p0cnt >= 3), 64'd1);
        v_drv[0]  = 1'b0;
        rr_drv[1] = 1'b1;
        #1;
        check_eq("bp_release_no_grant", 64'(bus.req_ready[1]), 64'd0);
        @(posedge clk);
        @(negedge clk); #1;
        check_eq("bp_consumed", 64'(bus.res_valid[1]), 64'd0);
        check_eq("bp_next_grant", 64'(bus.req_ready[1]), 64'd1);
        @(posedge clk); #1;
        v_drv[1] = 1'b0;
        n = 0;
        while (!bus.res_valid[1] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("bp_after_value", 64'(bus.res_out[63:32]), 64'd100);
        repeat (4) @(negedge clk);

        // Random operands and handshake gaps against the golden model.
        fork
            drive_port(0);
            drive_port(1);
            monitor_rand();
        join
        check_eq("rand_q0_empty", 64'(exp_q0.size()), 64'd0);
        check_eq("rand_q1_empty", 64'(exp_q1.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
